// File: rtl/counter_arbiter_pkg.sv
// Shared types, default sizes and round-robin helper for the interval counter arbiter.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable.
package counter_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;
  // Index width covers the largest supported requester count (8).
  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // First asserted request after last_winner, wrapping modulo num_req.
  // Returns last_winner unchanged when nothing is requested.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   last_winner,
    input int unsigned        num_req = DEF_NUM_REQ
  );
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = last_winner;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(last_winner) + k) % num_req;
      if (!found && (k <= num_req) && req[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Client-side bundle of the counter arbiter: level requests, lengths and per-client status.
// Latency: wires only.
// Backpressure: none; a client holds req high until done or until it wants to abort.
interface counter_arbiter_if
  import counter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [WIDTH-1:0]         count;

  modport master (output req, req_len, input grant, done, busy, count);
  modport slave  (input req, req_len, output grant, done, busy, count);
endinterface

// File: rtl/counter_arbiter_sync_counter.sv
// WIDTH-bit up counter with synchronous clear/enable and a terminal-match flag.
// Latency: count updates one edge after clr/en; tc is combinational from the count register.
// Backpressure: none; the owner sequences clr and en.
module sync_counter
  import counter_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] len,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  logic [WIDTH-1:0] count_q, count_d;

  // Clear wins over enable so a grant or abort always restarts from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == len);
endmodule

// File: rtl/counter_arbiter.sv
// Round-robin owner of one shared interval counter; grants (len+1) cycles then pulses done.
// Latency: grant one edge after req seen in IDLE; done one edge after the terminal count.
// Backpressure: losers wait with req held; dropping req mid-interval aborts without done.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  counter_arbiter_if.slave bus
);
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [WIDTH-1:0]   len_q, len_d;
  // last_q doubles as the current winner while in COUNT.
  logic [IDX_W-1:0]   last_q, last_d;
  logic [MAX_REQ-1:0] req_ext;
  logic [IDX_W-1:0]   pick;
  logic               cnt_clr, cnt_en, cnt_tc;
  logic [WIDTH-1:0]   cnt;

  assign req_ext = MAX_REQ'(bus.req);
  assign pick    = rr_pick(req_ext, last_q, unsigned'(NUM_REQ));

  // Next-state, grant/done and counter sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    len_d   = len_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = COUNT;
          len_d   = bus.req_len[int'(pick)*WIDTH +: WIDTH];
          grant_d = NUM_REQ'(1) << pick;
          last_d  = pick;
          cnt_clr = 1'b1;
        end
      end
      COUNT: begin
        if (!req_ext[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = DONE;
          grant_d = '0;
          done_d  = NUM_REQ'(1) << last_q;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // FSM and registered outputs; pointer resets so requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      len_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      len_q   <= len_d;
      last_q  <= last_d;
    end
  end

  sync_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .len   (len_q),
    .count (cnt),
    .tc    (cnt_tc)
  );

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.count = cnt;
endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: per-cycle vector table plus hand sequences for async reset and max length.
// Latency: each vector's expectation is compared #1 after the edge that consumes its inputs.
// Backpressure: not applicable.
module tb_counter_arbiter;
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  grant;
    logic [3:0]  count;
    logic [3:0]  done;
    logic        busy;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  vec_t vecs[$];
  vec_t exp_q[$];

  counter_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bus ();

  counter_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic rst, input logic [3:0] req, input logic [15:0] len,
                               input logic [3:0] g, input logic [3:0] c, input logic [3:0] d,
                               input logic b);
    vec_t v;
    v.rst = rst; v.req = req; v.len = len;
    v.grant = g; v.count = c; v.done = d; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input vec_t e);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(e.grant));
    chk({tag, ".count"}, 32'(bus.count), 32'(e.count));
    chk({tag, ".done"},  32'(bus.done),  32'(e.done));
    chk({tag, ".busy"},  32'(bus.busy),  32'(e.busy));
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    reset       = v.rst;
    bus.req     = v.req;
    bus.req_len = v.len;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      compare(tag, exp_q.pop_front());
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.req     = '0;
    bus.req_len = '0;

    // Single request, len0=3.
    vecs.push_back(mkv(1, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mkv(0, 4'h1, 16'h0003, 4'h1, 4'(k), 4'h0, 1));
    vecs.push_back(mkv(0, 4'h1, 16'h0003, 4'h0, 0, 4'h1, 1));
    vecs.push_back(mkv(0, 4'h0, 16'h0003, 4'h0, 0, 4'h0, 0));
    vecs.push_back(mkv(0, 4'h0, 16'h0003, 4'h0, 0, 4'h0, 0));
    // Contention from reset, all lengths 0: 1,2,4,8,1 with two idle cycles between grants.
    vecs.push_back(mkv(1, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 0));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h1, 0, 4'h0, 1));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h0, 0, 4'h1, 1));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h0, 0, 4'h0, 0));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h2, 0, 4'h0, 1));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h0, 0, 4'h2, 1));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h0, 0, 4'h0, 0));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h4, 0, 4'h0, 1));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h0, 0, 4'h4, 1));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h0, 0, 4'h0, 0));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h8, 0, 4'h0, 1));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h0, 0, 4'h8, 1));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h0, 0, 4'h0, 0));
    vecs.push_back(mkv(0, 4'hF, 16'h0000, 4'h1, 0, 4'h0, 1));
    vecs.push_back(mkv(0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 0));
    // Abort: req2 with len2=7, dropped while count shows 2.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mkv(0, 4'h4, 16'h0700, 4'h4, 4'(k), 4'h0, 1));
    vecs.push_back(mkv(0, 4'h0, 16'h0700, 4'h0, 0, 4'h0, 0));
    vecs.push_back(mkv(0, 4'h0, 16'h0700, 4'h0, 0, 4'h0, 0));
    // Length freeze: len1=5 at grant, changed to 1 afterwards; count still runs to 5.
    vecs.push_back(mkv(0, 4'h2, 16'h0050, 4'h2, 0, 4'h0, 1));
    for (int k = 1; k < 6; k++)
      vecs.push_back(mkv(0, 4'h2, 16'h0010, 4'h2, 4'(k), 4'h0, 1));
    vecs.push_back(mkv(0, 4'h2, 16'h0010, 4'h0, 0, 4'h2, 1));
    vecs.push_back(mkv(0, 4'h0, 16'h0010, 4'h0, 0, 4'h0, 0));

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // Reset mid-count: requester 3 granted, reset while count shows 3.
    for (int k = 0; k < 4; k++)
      step($sformatf("rst_pre%0d", k), mkv(0, 4'h8, 16'h5000, 4'h8, 4'(k), 4'h0, 1));
    #3;
    reset = 1'b1;
    #1;
    compare("rst_async", mkv(1, 4'h8, 16'h5000, 4'h0, 0, 4'h0, 0));
    @(posedge clk);
    #1;
    step("rst_after", mkv(0, 4'h9, 16'h0000, 4'h1, 0, 4'h0, 1));
    step("rst_drop",  mkv(0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 0));

    // Maximum length: 16 grant cycles, count reaches 15 without wrapping.
    for (int k = 0; k < 16; k++)
      step($sformatf("max%0d", k), mkv(0, 4'h1, 16'h000F, 4'h1, 4'(k), 4'h0, 1));
    step("max_done", mkv(0, 4'h1, 16'h000F, 4'h0, 0, 4'h1, 1));
    step("max_idle", mkv(0, 4'h0, 16'h000F, 4'h0, 0, 4'h0, 0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
